// File: rtl/multi_port_reg_files_pkg.sv
// Shared defaults, the hardwired-zero register index and a flattened-bus slice helper
// for the multi-port register file.
`ifndef MULTI_PORT_REG_FILES_PKG_SV
`define MULTI_PORT_REG_FILES_PKG_SV

// Port i of a flattened bus v whose fields are w bits wide.
`define MPRF_SLICE(v, i, w) v[(i)*(w) +: (w)]

package multi_port_reg_files_pkg;
  localparam int unsigned NUM_RD_DEF = 4;
  localparam int unsigned NUM_WR_DEF = 2;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned ZERO_REG   = 0;
endpackage

`endif

// File: rtl/multi_port_reg_files_reg_scoreboard.sv
// Busy scoreboard: one bit per register, set by issue allocation, cleared by
// writeback, wiped by flush. Register 0 never becomes busy.
module multi_port_reg_files_reg_scoreboard
  import multi_port_reg_files_pkg::*;
#(
  parameter int unsigned NUM_WR = NUM_WR_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        alloc_en,
  input  logic [NUM_WR*ADDR_W-1:0] alloc_addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     flush,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);
  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] set_c, clr_c;

  // A new producer (set) wins over a retiring one (clr); flush wins over both.
  always_comb begin
    set_c = '0;
    clr_c = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (alloc_en[k]) set_c[`MPRF_SLICE(alloc_addr, k, ADDR_W)] = 1'b1;
      if (wr_en[k])    clr_c[`MPRF_SLICE(wr_addr, k, ADDR_W)]    = 1'b1;
    end
    set_c[ZERO_REG] = 1'b0;
    busy_d = flush ? '0 : ((busy_q & ~clr_c) | set_c);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign busy_vec = busy_q;
endmodule

// File: rtl/multi_port_reg_files.sv
// Multi-ported general-purpose register file with optional write-to-read bypass
// and an integrated busy scoreboard. Register 0 reads as zero.
module multi_port_reg_files
  import multi_port_reg_files_pkg::*;
#(
  parameter int unsigned NUM_RD = NUM_RD_DEF,
  parameter int unsigned NUM_WR = NUM_WR_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR-1:0]        alloc_en,
  input  logic [NUM_WR*ADDR_W-1:0] alloc_addr,
  input  logic                     flush,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);
  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0] raddr_c [NUM_RD];
  logic [DATA_W-1:0] rval_c  [NUM_RD];
  logic [NUM_RD-1:0] hit_c;

  multi_port_reg_files_reg_scoreboard #(
    .NUM_WR (NUM_WR),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .flush      (flush),
    .busy_vec   (busy_vec)
  );

  // Ascending port order lets the highest-numbered writer win on a collision.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_en[k] && (`MPRF_SLICE(wr_addr, k, ADDR_W) != ADDR_W'(ZERO_REG)))
        mem_d[`MPRF_SLICE(wr_addr, k, ADDR_W)] = `MPRF_SLICE(wr_data, k, DATA_W);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads are forced to zero while reset is held so bypassed writes cannot leak out.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    hit_c   = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      raddr_c[j] = `MPRF_SLICE(rd_addr, j, ADDR_W);
      rval_c[j]  = mem_q[raddr_c[j]];
      if (BYPASS) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_en[k] && (`MPRF_SLICE(wr_addr, k, ADDR_W) == raddr_c[j])) begin
            hit_c[j]  = 1'b1;
            rval_c[j] = `MPRF_SLICE(wr_data, k, DATA_W);
          end
        end
      end
      if (rst && rd_en[j] && (raddr_c[j] != ADDR_W'(ZERO_REG))) begin
        `MPRF_SLICE(rd_data, j, DATA_W) = rval_c[j];
        rd_busy[j] = busy_vec[raddr_c[j]] & ~hit_c[j];
      end
    end
  end
endmodule

// File: tb/tb_multi_port_reg_files.sv
// Self-checking bench for multi_port_reg_files: directed scenarios plus randomized
// traffic against an array/bit-vector reference model, with BYPASS=1 and BYPASS=0 instances.
module tb_multi_port_reg_files;
  localparam int NRD = 4;
  localparam int NWR = 2;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int DEP = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic [NRD-1:0]    rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data_b1, rd_data_b0;
  logic [NRD-1:0]    rd_busy_b1, rd_busy_b0;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic [NWR-1:0]    alloc_en;
  logic [NWR*AW-1:0] alloc_addr;
  logic              flush;
  logic [DEP-1:0]    busy_vec_b1, busy_vec_b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0]  m_mem [DEP];
  logic [DEP-1:0] m_busy;

  always #5 clk = ~clk;

  multi_port_reg_files #(.NUM_RD(NRD), .NUM_WR(NWR), .DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b1)) dut_b1 (
    .clk(clk), .rst(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b1),
    .rd_busy(rd_busy_b1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush), .busy_vec(busy_vec_b1));

  multi_port_reg_files #(.NUM_RD(NRD), .NUM_WR(NWR), .DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b0)) dut_b0 (
    .clk(clk), .rst(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b0),
    .rd_busy(rd_busy_b0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush), .busy_vec(busy_vec_b0));

  task automatic idle();
    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = '0; alloc_addr = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int j, input logic [AW-1:0] a);
    rd_en[j] = 1'b1; rd_addr[j*AW +: AW] = a;
  endtask

  task automatic set_wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[k] = 1'b1; wr_addr[k*AW +: AW] = a; wr_data[k*DW +: DW] = d;
  endtask

  task automatic set_alloc(input int k, input logic [AW-1:0] a);
    alloc_en[k] = 1'b1; alloc_addr[k*AW +: AW] = a;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEP; i++) m_mem[i] = '0;
    m_busy = '0;
  endtask

  // Reference register-file behaviour at a rising edge.
  task automatic tick();
    logic [DEP-1:0] nb;
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      nb = m_busy;
      for (int k = 0; k < NWR; k++) begin
        int a = int'(wr_addr[k*AW +: AW]);
        if (wr_en[k]) nb[a] = 1'b0;
        if (wr_en[k] && a != 0) m_mem[a] = wr_data[k*DW +: DW];
      end
      for (int k = 0; k < NWR; k++)
        if (alloc_en[k]) nb[int'(alloc_addr[k*AW +: AW])] = 1'b1;
      if (flush) nb = '0;
      nb[0] = 1'b0;
      m_busy = nb;
    end
  endtask

  function automatic logic [NRD*DW-1:0] exp_data(input bit byp);
    logic [NRD*DW-1:0] r = '0;
    for (int j = 0; j < NRD; j++) begin
      int a = int'(rd_addr[j*AW +: AW]);
      logic [DW-1:0] v = m_mem[a];
      if (byp)
        for (int k = 0; k < NWR; k++)
          if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a) v = wr_data[k*DW +: DW];
      if (rst_n && rd_en[j] && a != 0) r[j*DW +: DW] = v;
    end
    return r;
  endfunction

  function automatic logic [NRD-1:0] exp_busy(input bit byp);
    logic [NRD-1:0] r = '0;
    for (int j = 0; j < NRD; j++) begin
      int a = int'(rd_addr[j*AW +: AW]);
      bit hit = 1'b0;
      for (int k = 0; k < NWR; k++)
        if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a) hit = 1'b1;
      r[j] = rst_n && rd_en[j] && a != 0 && m_busy[a] && !(byp && hit);
    end
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; model_clear(); idle();
    set_wr(0, 5'd3, 32'hDEADBEEF); set_rd(0, 5'd3); set_alloc(1, 5'd3);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (rd_data_b1 !== '0 || rd_busy_b1 !== '0 || busy_vec_b1 !== '0) begin
      n_fail++; $display("FAIL reset_hold: data=%h busy=%b vec=%h required all zero", rd_data_b1, rd_busy_b1, busy_vec_b1);
    end
    @(negedge clk); rst_n = 1'b1; idle(); set_rd(0, 5'd3);
    #1;
    n_checks++;
    if (rd_data_b1[31:0] !== 32'h0 || busy_vec_b1 !== '0) begin
      n_fail++; $display("FAIL reset_release: r3=%h vec=%h required 0/0", rd_data_b1[31:0], busy_vec_b1);
    end
    tick();
    // Asynchronous reset mid-cycle with a write and an alloc in flight.
    @(negedge clk); idle(); set_wr(0, 5'd3, 32'hCAFE0001); set_alloc(0, 5'd10); tick();
    @(negedge clk); idle(); set_wr(0, 5'd3, 32'hDEADBEEF); set_alloc(1, 5'd11);
    #2; rst_n = 1'b0; model_clear(); #1;
    n_checks++;
    if (busy_vec_b1 !== '0 || busy_vec_b0 !== '0) begin
      n_fail++; $display("FAIL reset_async: vec=%h/%h required 0", busy_vec_b1, busy_vec_b0);
    end
    tick();
    @(negedge clk); rst_n = 1'b1; idle(); set_rd(0, 5'd3); set_rd(1, 5'd10);
    #1;
    n_checks++;
    if (rd_data_b1[31:0] !== 32'h0 || rd_data_b0[31:0] !== 32'h0 || rd_busy_b1 !== '0) begin
      n_fail++; $display("FAIL reset_async_r3: r3=%h/%h busy=%b required 0", rd_data_b1[31:0], rd_data_b0[31:0], rd_busy_b1);
    end
    tick();
  endtask

  task automatic test_write_priority();
    @(negedge clk); idle(); set_wr(0, 5'd5, 32'h11111111); set_wr(1, 5'd5, 32'h22222222); set_rd(0, 5'd5);
    #1;
    n_checks++;
    if (rd_data_b1[31:0] !== 32'h22222222) begin
      n_fail++; $display("FAIL bypass_prio: got %h required 22222222", rd_data_b1[31:0]);
    end
    n_checks++;
    if (rd_data_b0[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL nobypass_old: got %h required 00000000", rd_data_b0[31:0]);
    end
    tick();
    @(negedge clk); idle(); set_rd(2, 5'd5);
    #1;
    n_checks++;
    if (rd_data_b1[95:64] !== 32'h22222222 || rd_data_b0[95:64] !== 32'h22222222) begin
      n_fail++; $display("FAIL write_prio: got %h/%h required 22222222", rd_data_b1[95:64], rd_data_b0[95:64]);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    @(negedge clk); idle(); set_wr(0, 5'd0, 32'hFFFFFFFF); set_alloc(0, 5'd0); set_rd(1, 5'd0);
    #1;
    n_checks++;
    if (rd_data_b1[63:32] !== 32'h0) begin
      n_fail++; $display("FAIL r0_bypass: got %h required 0", rd_data_b1[63:32]);
    end
    tick();
    @(negedge clk); idle(); set_rd(0, 5'd0); set_wr(1, 5'd7, 32'h5);
    #1;
    n_checks++;
    if (rd_data_b1[31:0] !== 32'h0 || rd_data_b0[31:0] !== 32'h0 || busy_vec_b1[0] !== 1'b0 || rd_busy_b1 !== '0) begin
      n_fail++; $display("FAIL r0_read: got %h/%h busy0=%b required 0", rd_data_b1[31:0], rd_data_b0[31:0], busy_vec_b1[0]);
    end
    tick();
    @(negedge clk); idle(); rd_addr[1*AW +: AW] = 5'd7; set_rd(2, 5'd7);
    #1;
    n_checks++;
    if (rd_data_b1[63:32] !== 32'h0 || rd_data_b1[95:64] !== 32'h5) begin
      n_fail++; $display("FAIL rd_en_gate: disabled=%h enabled=%h required 0/5", rd_data_b1[63:32], rd_data_b1[95:64]);
    end
    tick();
  endtask

  task automatic test_busy_flow();
    @(negedge clk); idle(); set_alloc(0, 5'd9); tick();
    @(negedge clk); idle(); set_rd(3, 5'd9);
    #1;
    n_checks++;
    if (rd_busy_b1[3] !== 1'b1 || rd_busy_b0[3] !== 1'b1 || busy_vec_b1[9] !== 1'b1) begin
      n_fail++; $display("FAIL busy_after_alloc: got %b/%b required 1", rd_busy_b1[3], rd_busy_b0[3]);
    end
    tick();
    @(negedge clk); idle(); set_rd(3, 5'd9); set_wr(1, 5'd9, 32'h0000ABCD);
    #1;
    n_checks++;
    if (rd_data_b1[127:96] !== 32'h0000ABCD || rd_busy_b1[3] !== 1'b0) begin
      n_fail++; $display("FAIL wb_bypass: data=%h busy=%b required 0000abcd/0", rd_data_b1[127:96], rd_busy_b1[3]);
    end
    n_checks++;
    if (rd_data_b0[127:96] !== 32'h0 || rd_busy_b0[3] !== 1'b1) begin
      n_fail++; $display("FAIL wb_nobypass: data=%h busy=%b required 0/1", rd_data_b0[127:96], rd_busy_b0[3]);
    end
    tick();
    @(negedge clk); idle();
    #1;
    n_checks++;
    if (busy_vec_b1[9] !== 1'b0 || busy_vec_b0[9] !== 1'b0) begin
      n_fail++; $display("FAIL busy_release: got %b/%b required 0", busy_vec_b1[9], busy_vec_b0[9]);
    end
  endtask

  task automatic test_set_beats_clear();
    @(negedge clk); idle(); set_alloc(1, 5'd4); set_wr(0, 5'd4, 32'h44); tick();
    @(negedge clk); idle();
    #1;
    n_checks++;
    if (busy_vec_b1 !== 32'h0000_0010) begin
      n_fail++; $display("FAIL set_beats_clr: vec=%h required 00000010", busy_vec_b1);
    end
    set_wr(0, 5'd4, 32'h45); tick();
  endtask

  task automatic test_flush();
    @(negedge clk); idle(); set_alloc(0, 5'd2); set_alloc(1, 5'd6); tick();
    @(negedge clk); idle();
    #1;
    n_checks++;
    if (busy_vec_b1 !== 32'h0000_0044) begin
      n_fail++; $display("FAIL pre_flush: vec=%h required 00000044", busy_vec_b1);
    end
    flush = 1'b1; set_alloc(0, 5'd8); set_wr(1, 5'd6, 32'h77); tick();
    @(negedge clk); idle(); set_rd(0, 5'd6);
    #1;
    n_checks++;
    if (busy_vec_b1 !== '0 || busy_vec_b0 !== '0 || rd_data_b1[31:0] !== 32'h77 || rd_data_b0[31:0] !== 32'h77) begin
      n_fail++; $display("FAIL flush: vec=%h r6=%h required 0/00000077", busy_vec_b1, rd_data_b1[31:0]);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); idle();
      for (int j = 0; j < NRD; j++) begin
        rd_en[j] = ($urandom_range(0, 3) != 0);
        rd_addr[j*AW +: AW] = AW'($urandom_range(0, 9));
      end
      for (int k = 0; k < NWR; k++) begin
        wr_en[k] = $urandom_range(0, 1) == 1;
        wr_addr[k*AW +: AW] = AW'($urandom_range(0, 9));
        wr_data[k*DW +: DW] = $urandom;
        alloc_en[k] = $urandom_range(0, 1) == 1;
        alloc_addr[k*AW +: AW] = AW'($urandom_range(0, 9));
      end
      flush = ($urandom_range(0, 15) == 0);
      #1;
      n_checks++;
      if (rd_data_b1 !== exp_data(1'b1) || rd_busy_b1 !== exp_busy(1'b1)) begin
        n_fail++; $display("FAIL rand_b1 c=%0d: data=%h busy=%b required %h/%b", c, rd_data_b1, rd_busy_b1, exp_data(1'b1), exp_busy(1'b1));
      end
      n_checks++;
      if (rd_data_b0 !== exp_data(1'b0) || rd_busy_b0 !== exp_busy(1'b0)) begin
        n_fail++; $display("FAIL rand_b0 c=%0d: data=%h busy=%b required %h/%b", c, rd_data_b0, rd_busy_b0, exp_data(1'b0), exp_busy(1'b0));
      end
      n_checks++;
      if (busy_vec_b1 !== m_busy || busy_vec_b0 !== m_busy) begin
        n_fail++; $display("FAIL rand_vec c=%0d: got %h/%h required %h", c, busy_vec_b1, busy_vec_b0, m_busy);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_priority();
    test_zero_reg();
    test_busy_flow();
    test_set_beats_clear();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
